divisor_despachador: RTL and testbench
======================================

Name: divisor_despachador

Overview:
- Upstream/downstream companion stage to the sequential binary divider core.
- Accepts signed operand pairs over a valid/ready input stream and buffers them in a small FIFO.
- Converts each pair to magnitudes, drives the divider's Start/Num/Den interface and waits for Done.
- Re-applies signs to the result and presents the signed quotient and remainder on a valid/ready output stream.
- Divide-by-zero is handled locally; the divider is never started for Den = 0.

Parameters:
tamanyo, 32, operand/result width in bits (must match the divider core)
profundidad, 4, FIFO depth in operand pairs (power of two, >= 2)

Ports:
CLK  in  1  clock, rising edge
RSTa  in  1  asynchronous active-low reset
In_valid  in  1  operand pair valid
In_ready  out  1  FIFO can accept a pair
In_num  in  tamanyo  signed dividend (two's complement)
In_den  in  tamanyo  signed divisor (two's complement)
Div_start  out  1  one-cycle start pulse to divider core
Div_num  out  tamanyo  unsigned dividend magnitude to core
Div_den  out  tamanyo  unsigned divisor magnitude to core
Div_coc  in  tamanyo  unsigned quotient from core
Div_rec  in  tamanyo  unsigned remainder from core
Div_done  in  1  core completion pulse; Div_coc/Div_rec valid in that cycle
Out_valid  out  1  result valid
Out_ready  in  1  consumer accepts result
Out_coc  out  tamanyo  signed quotient
Out_rec  out  tamanyo  signed remainder
Out_dz  out  1  divide-by-zero flag for the presented result
Busy  out  1  high when state != IDLE or FIFO not empty

Behaviour:
- Reset (RSTa = 0, asynchronous):
  - state = IDLE; FIFO empty (pointers and count = 0).
  - Div_start, Out_valid and Out_dz are 0; Div_num, Div_den, Out_coc and Out_rec are 0.
  - In_ready is 1 once RSTa deasserts.
  - The divider core shares RSTa, so a reset mid-operation aborts both blocks cleanly. No partial result is emitted.
- FIFO:
  - Push when In_valid && In_ready.
  - In_ready = !full, decoded from the registered count only. A pop in the same cycle does not allow a push into a full FIFO.
  - Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
  - Pointers wrap modulo profundidad.
- FSM, states IDLE, LOAD, WAIT, OUT:
  - IDLE: if FIFO is non-empty, pop the head and register:
    - sn = num[MSB], sd = den[MSB];
    - mag_n = |num|, mag_d = |den|;
    - dz = (den == 0).
    - Go to LOAD.
  - LOAD, if dz:
    - Out_coc = all ones, Out_rec = original num, Out_dz = 1.
    - Go to OUT. Div_start stays 0.
  - LOAD, otherwise:
    - Div_num = mag_n, Div_den = mag_d, Div_start = 1 for exactly this cycle.
    - Go to WAIT.
  - WAIT:
    - Div_num and Div_den are held stable.
    - On Div_done, capture the results:
      - Out_coc = (sn ^ sd) ? -Div_coc : Div_coc;
      - Out_rec = sn ? -Div_rec : Div_rec;
      - Out_dz = 0.
    - Go to OUT.
  - OUT:
    - Out_valid = 1. Out_coc, Out_rec and Out_dz are held stable until Out_ready.
    - On Out_valid && Out_ready, Out_valid drops on the next edge and the FSM returns to IDLE.
- Div_done outside WAIT is ignored.
- Arithmetic:
  - Negation is two's complement at width tamanyo.
  - |most-negative| = 2^(tamanyo-1), which fits unsigned.
  - most-negative / -1 therefore yields quotient most-negative (wraps, no flag) and remainder 0.
- Latency:
  - Pop occurs on the first edge after the FIFO becomes non-empty.
  - Div_start is high in the cycle after the pop.
  - Out_valid rises on the edge after Div_done is sampled.
  - Divide-by-zero: Out_valid rises on the edge after LOAD.
- Throughput: one division in flight at a time. Pairs pushed during WAIT or OUT queue in the FIFO. Maximum held pairs = profundidad + 1 (one in the FSM).

Decomposition:
- Shared package divisor_pkg: the state enum type (IDLE, LOAD, WAIT, OUT) and the functions abs_val and neg_if.
- Natural sub-module: divisor_fifo (parameterised width and depth; push/pop/full/empty/count), instantiated once with width 2*tamanyo.
- The FSM and sign handling stay in divisor_despachador.

Test Plan:
- Push 7 / 2 with Out_ready = 1 and a behavioural core model:
  - Div_start pulses once with Div_num = 7, Div_den = 2.
  - Out_coc = 3, Out_rec = 1, Out_dz = 0.
- Push -7 / 2:
  - Core sees 7 / 2.
  - Out_coc = 0xFFFFFFFD (-3), Out_rec = 0xFFFFFFFF (-1).
- Push 7 / 0:
  - Div_start never asserts.
  - Out_coc = 0xFFFFFFFF, Out_rec = 7, Out_dz = 1.
- Push 0x80000000 / 0xFFFFFFFF:
  - Core sees 0x80000000 / 1.
  - Out_coc = 0x80000000, Out_rec = 0.
- Hold Out_ready = 0 and stream 6 pairs:
  - In_ready falls after the 5th accepted pair.
  - Out_* stays stable while stalled.
  - Release Out_ready: all 5 results emerge in push order.
- Assert RSTa = 0 during WAIT:
  - Out_valid, Div_start and Busy are 0 immediately, and the FIFO is empty.
  - The next pushed pair, 9 / 3, completes with Out_coc = 3, Out_rec = 0.

Source files
------------

// File: rtl/divisor_pkg.sv
// divisor_pkg: shared types and sign helpers
// for the divider dispatch stage.
package divisor_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    OUT
  } state_t;

  function automatic logic [MAX_W-1:0] neg_if(
    input logic [MAX_W-1:0] v,
    input logic             s
  );
    return s ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [MAX_W-1:0] abs_val(
    input logic [MAX_W-1:0] v,
    input int unsigned      w
  );
    logic s;
    s = 1'(v >> (w - 1));
    return neg_if(v, s);
  endfunction

endpackage

// File: rtl/divisor_fifo.sv
// divisor_fifo: small power-of-two FIFO
// with registered occupancy count.
module divisor_fifo #(
  parameter int W = 64,
  parameter int D = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [W-1:0]       wdata,
  output logic [W-1:0]       rdata,
  output logic               full,
  output logic               empty,
  output logic [$clog2(D):0] count
);

  localparam int AW = $clog2(D);

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full    = (count_q == (AW+1)'(D));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // pointer and occupancy update; pointers wrap naturally
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // control registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage, qualified by occupancy so no reset needed
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/divisor_despachador.sv
// divisor_despachador: queues signed pairs, drives
// the unsigned divider core, re-signs the results.
module divisor_despachador
  import divisor_pkg::*;
#(
  parameter int tamanyo     = 32,
  parameter int profundidad = 4
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               In_valid,
  output logic               In_ready,
  input  logic [tamanyo-1:0] In_num,
  input  logic [tamanyo-1:0] In_den,
  output logic               Div_start,
  output logic [tamanyo-1:0] Div_num,
  output logic [tamanyo-1:0] Div_den,
  input  logic [tamanyo-1:0] Div_coc,
  input  logic [tamanyo-1:0] Div_rec,
  input  logic               Div_done,
  output logic               Out_valid,
  input  logic               Out_ready,
  output logic [tamanyo-1:0] Out_coc,
  output logic [tamanyo-1:0] Out_rec,
  output logic               Out_dz,
  output logic               Busy
);

  localparam int W = tamanyo;

  logic [2*W-1:0] f_rdata;
  logic           f_full, f_empty, f_pop;
  logic [$clog2(profundidad):0] f_count;
  logic [W-1:0]   num, den;

  state_t       state_q, state_d;
  logic         sn_q, sn_d, sd_q, sd_d, dz_q, dz_d;
  logic [W-1:0] mag_n_q, mag_n_d, mag_d_q, mag_d_d;
  logic [W-1:0] out_coc_q, out_coc_d;
  logic [W-1:0] out_rec_q, out_rec_d;
  logic         out_dz_q, out_dz_d;

  divisor_fifo #(
    .W(2*W),
    .D(profundidad)
  ) u_fifo (
    .clk   (CLK),
    .rst_n (RSTa),
    .push  (In_valid && In_ready),
    .pop   (f_pop),
    .wdata ({In_num, In_den}),
    .rdata (f_rdata),
    .full  (f_full),
    .empty (f_empty),
    .count (f_count)
  );

  assign num       = f_rdata[2*W-1:W];
  assign den       = f_rdata[W-1:0];
  assign In_ready  = !f_full;
  assign Div_start = (state_q == LOAD) && !dz_q;
  assign Div_num   = mag_n_q;
  assign Div_den   = mag_d_q;
  assign Out_valid = (state_q == OUT);
  assign Out_coc   = out_coc_q;
  assign Out_rec   = out_rec_q;
  assign Out_dz    = out_dz_q;
  assign Busy      = (state_q != IDLE) || (f_count != '0);

  // dispatch FSM: pop, start core or short-cut /0, re-sign, present
  always_comb begin
    state_d   = state_q;
    sn_d      = sn_q;
    sd_d      = sd_q;
    dz_d      = dz_q;
    mag_n_d   = mag_n_q;
    mag_d_d   = mag_d_q;
    out_coc_d = out_coc_q;
    out_rec_d = out_rec_q;
    out_dz_d  = out_dz_q;
    f_pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!f_empty) begin
          f_pop   = 1'b1;
          sn_d    = num[W-1];
          sd_d    = den[W-1];
          mag_n_d = W'(abs_val(MAX_W'(num), W));
          mag_d_d = W'(abs_val(MAX_W'(den), W));
          dz_d    = (den == '0);
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (dz_q) begin
          out_coc_d = '1;
          out_rec_d = W'(neg_if(MAX_W'(mag_n_q), sn_q));
          out_dz_d  = 1'b1;
          state_d   = OUT;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (Div_done) begin
          out_coc_d = W'(neg_if(MAX_W'(Div_coc), sn_q ^ sd_q));
          out_rec_d = W'(neg_if(MAX_W'(Div_rec), sn_q));
          out_dz_d  = 1'b0;
          state_d   = OUT;
        end
      end
      OUT: begin
        if (Out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      state_q   <= IDLE;
      sn_q      <= 1'b0;
      sd_q      <= 1'b0;
      dz_q      <= 1'b0;
      mag_n_q   <= '0;
      mag_d_q   <= '0;
      out_coc_q <= '0;
      out_rec_q <= '0;
      out_dz_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sn_q      <= sn_d;
      sd_q      <= sd_d;
      dz_q      <= dz_d;
      mag_n_q   <= mag_n_d;
      mag_d_q   <= mag_d_d;
      out_coc_q <= out_coc_d;
      out_rec_q <= out_rec_d;
      out_dz_q  <= out_dz_d;
    end
  end

endmodule

// File: tb/tb_divisor_despachador.sv
// tb_divisor_despachador: directed checks of the
// dispatch stage against a behavioural divider core.
module tb_divisor_despachador;

  logic        CLK = 1'b0;
  logic        RSTa;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] In_num, In_den;
  logic        Div_start;
  logic [31:0] Div_num, Div_den;
  logic [31:0] Div_coc, Div_rec;
  logic        Div_done;
  logic        Out_valid, Out_ready;
  logic [31:0] Out_coc, Out_rec;
  logic        Out_dz;
  logic        Busy;

  int n_checks = 0;
  int n_fail   = 0;

  int          start_cnt = 0;
  int          m_cnt;
  logic [31:0] m_num, m_den;

  divisor_despachador dut (
    .CLK       (CLK),
    .RSTa      (RSTa),
    .In_valid  (In_valid),
    .In_ready  (In_ready),
    .In_num    (In_num),
    .In_den    (In_den),
    .Div_start (Div_start),
    .Div_num   (Div_num),
    .Div_den   (Div_den),
    .Div_coc   (Div_coc),
    .Div_rec   (Div_rec),
    .Div_done  (Div_done),
    .Out_valid (Out_valid),
    .Out_ready (Out_ready),
    .Out_coc   (Out_coc),
    .Out_rec   (Out_rec),
    .Out_dz    (Out_dz),
    .Busy      (Busy)
  );

  always #5 CLK = ~CLK;

  // behavioural unsigned divider, done three cycles after start
  always @(posedge CLK or negedge RSTa) begin
    if (!RSTa) begin
      m_cnt    <= 0;
      Div_done <= 1'b0;
      Div_coc  <= '0;
      Div_rec  <= '0;
    end else begin
      Div_done <= 1'b0;
      if (m_cnt != 0) begin
        m_cnt <= m_cnt - 1;
        if (m_cnt == 1) begin
          Div_done <= 1'b1;
          Div_coc  <= m_num / m_den;
          Div_rec  <= m_num % m_den;
        end
      end
      if (Div_start) begin
        m_cnt     <= 3;
        m_num     <= Div_num;
        m_den     <= Div_den;
        start_cnt <= start_cnt + 1;
      end
    end
  end

  task automatic push(input logic [31:0] n, input logic [31:0] d,
                      output bit ok);
    ok = 1'b0;
    In_num = n;
    In_den = d;
    In_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (In_ready) begin
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
    In_valid = 1'b0;
  endtask

  task automatic collect(output logic [31:0] coc, output logic [31:0] rec,
                         output logic dz, output bit ok);
    ok = 1'b0;
    coc = 'x;
    rec = 'x;
    dz = 1'bx;
    Out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (Out_valid) begin
        coc = Out_coc;
        rec = Out_rec;
        dz = Out_dz;
        @(posedge CLK);
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    @(negedge CLK);
  endtask

  task automatic do_div(input logic [31:0] n, input logic [31:0] d,
                        output logic [31:0] coc, output logic [31:0] rec,
                        output logic dz, output int starts, output bit ok);
    bit ok1, ok2;
    int s0;
    s0 = start_cnt;
    push(n, d, ok1);
    collect(coc, rec, dz, ok2);
    starts = start_cnt - s0;
    ok = ok1 && ok2;
  endtask

  task automatic test_reset();
    RSTa = 1'b0;
    #1;
    n_checks++;
    if (Out_valid !== 1'b0 || Div_start !== 1'b0 || Out_dz !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got valid=%b start=%b dz=%b required 0 0 0",
               Out_valid, Div_start, Out_dz);
    end
    n_checks++;
    if (Out_coc !== 32'd0 || Out_rec !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_out: got coc=%h rec=%h required 0 0", Out_coc, Out_rec);
    end
    n_checks++;
    if (Div_num !== 32'd0 || Div_den !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_div: got num=%h den=%h required 0 0", Div_num, Div_den);
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_busy: got %b required 0", Busy);
    end
    repeat (2) @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    n_checks++;
    if (In_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", In_ready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] coc, rec;
    logic dz;
    int st;
    bit ok;
    do_div(32'd7, 32'd2, coc, rec, dz, st, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL basic_timeout: got no handshake required completion");
    end
    n_checks++;
    if (st != 1) begin
      n_fail++;
      $display("FAIL basic_starts: got %0d required 1", st);
    end
    n_checks++;
    if (m_num !== 32'd7 || m_den !== 32'd2) begin
      n_fail++;
      $display("FAIL basic_core_ops: got %h/%h required 7/2", m_num, m_den);
    end
    n_checks++;
    if (coc !== 32'd3 || rec !== 32'd1 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_result: got %h r %h dz %b required 3 r 1 dz 0",
               coc, rec, dz);
    end
  endtask

  task automatic test_negative();
    logic [31:0] coc, rec;
    logic dz;
    int st;
    bit ok;
    do_div(32'hFFFF_FFF9, 32'd2, coc, rec, dz, st, ok);
    n_checks++;
    if (!ok || st != 1) begin
      n_fail++;
      $display("FAIL neg_flow: got ok=%b starts=%0d required 1 1", ok, st);
    end
    n_checks++;
    if (m_num !== 32'd7 || m_den !== 32'd2) begin
      n_fail++;
      $display("FAIL neg_core_ops: got %h/%h required 7/2", m_num, m_den);
    end
    n_checks++;
    if (coc !== 32'hFFFF_FFFD || rec !== 32'hFFFF_FFFF || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL neg_result: got %h r %h dz %b required fffffffd r ffffffff dz 0",
               coc, rec, dz);
    end
  endtask

  task automatic test_div_zero();
    logic [31:0] coc, rec;
    logic dz;
    int st;
    bit ok;
    do_div(32'd7, 32'd0, coc, rec, dz, st, ok);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL dz_timeout: got no handshake required completion");
    end
    n_checks++;
    if (st != 0) begin
      n_fail++;
      $display("FAIL dz_starts: got %0d required 0", st);
    end
    n_checks++;
    if (coc !== 32'hFFFF_FFFF || rec !== 32'd7 || dz !== 1'b1) begin
      n_fail++;
      $display("FAIL dz_result: got %h r %h dz %b required ffffffff r 7 dz 1",
               coc, rec, dz);
    end
  endtask

  task automatic test_most_negative();
    logic [31:0] coc, rec;
    logic dz;
    int st;
    bit ok;
    do_div(32'h8000_0000, 32'hFFFF_FFFF, coc, rec, dz, st, ok);
    n_checks++;
    if (!ok || st != 1) begin
      n_fail++;
      $display("FAIL minneg_flow: got ok=%b starts=%0d required 1 1", ok, st);
    end
    n_checks++;
    if (m_num !== 32'h8000_0000 || m_den !== 32'd1) begin
      n_fail++;
      $display("FAIL minneg_core_ops: got %h/%h required 80000000/1", m_num, m_den);
    end
    n_checks++;
    if (coc !== 32'h8000_0000 || rec !== 32'd0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL minneg_result: got %h r %h dz %b required 80000000 r 0 dz 0",
               coc, rec, dz);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] pn [5], pd [5], ec [5], er [5];
    logic        ed [5];
    logic [31:0] coc, rec, c0, r0;
    logic        dz;
    bit          ok, all_ok, seen_ready;
    pn = '{32'd10, 32'hFFFF_FFF6, 32'd10, 32'hFFFF_FFF6, 32'd20};
    pd = '{32'd3, 32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd0};
    ec = '{32'd3, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'd3, 32'hFFFF_FFFF};
    er = '{32'd1, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 32'd20};
    ed = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    Out_ready = 1'b0;
    all_ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      push(pn[k], pd[k], ok);
      all_ok = all_ok && ok;
    end
    n_checks++;
    if (!all_ok) begin
      n_fail++;
      $display("FAIL bp_accept5: got a refused push required 5 accepted");
    end
    n_checks++;
    if (In_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full: got In_ready=%b required 0", In_ready);
    end
    In_num = 32'd99;
    In_den = 32'd9;
    In_valid = 1'b1;
    seen_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      if (In_ready) seen_ready = 1'b1;
    end
    In_valid = 1'b0;
    n_checks++;
    if (seen_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_sixth: got In_ready=1 while stalled required 0");
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (Out_valid) begin
        ok = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    c0 = Out_coc;
    r0 = Out_rec;
    repeat (4) @(negedge CLK);
    n_checks++;
    if (!ok || Out_valid !== 1'b1 || Out_coc !== c0 || Out_rec !== r0) begin
      n_fail++;
      $display("FAIL bp_stable: got valid=%b coc=%h rec=%h required 1 %h %h",
               Out_valid, Out_coc, Out_rec, c0, r0);
    end
    for (int k = 0; k < 5; k++) begin
      collect(coc, rec, dz, ok);
      n_checks++;
      if (!ok || coc !== ec[k] || rec !== er[k] || dz !== ed[k]) begin
        n_fail++;
        $display("FAIL bp_result%0d: got ok=%b %h r %h dz %b required %h r %h dz %b",
                 k, ok, coc, rec, dz, ec[k], er[k], ed[k]);
      end
    end
    n_checks++;
    if (Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drained: got Busy=%b required 0", Busy);
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] coc, rec;
    logic dz;
    int st, s0;
    bit ok, got;
    Out_ready = 1'b1;
    s0 = start_cnt;
    push(32'd100, 32'd7, ok);
    push(32'd50, 32'd5, ok);
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (start_cnt != s0) begin
        got = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    n_checks++;
    if (!got) begin
      n_fail++;
      $display("FAIL rstw_start: got no Div_start required one");
    end
    RSTa = 1'b0;
    #1;
    n_checks++;
    if (Out_valid !== 1'b0 || Div_start !== 1'b0 || Busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_clear: got valid=%b start=%b busy=%b required 0 0 0",
               Out_valid, Div_start, Busy);
    end
    @(negedge CLK);
    RSTa = 1'b1;
    @(negedge CLK);
    do_div(32'd9, 32'd3, coc, rec, dz, st, ok);
    n_checks++;
    if (!ok || st != 1) begin
      n_fail++;
      $display("FAIL rstw_flow: got ok=%b starts=%0d required 1 1", ok, st);
    end
    n_checks++;
    if (coc !== 32'd3 || rec !== 32'd0 || dz !== 1'b0) begin
      n_fail++;
      $display("FAIL rstw_result: got %h r %h dz %b required 3 r 0 dz 0",
               coc, rec, dz);
    end
  endtask

  initial begin
    RSTa = 1'b0;
    In_valid = 1'b0;
    In_num = '0;
    In_den = '0;
    Out_ready = 1'b1;
    test_reset();
    test_basic();
    test_negative();
    test_div_zero();
    test_most_negative();
    test_back_pressure();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
